// File: rtl/alu_pipe_pkg.sv
// alu_pkg: op and state encodings plus flag bit positions shared by alu_pipe
// and its multiplier. Flags are packed as {Z, N, C, V}.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f        = '0;
        f[FLG_Z] = z;
        f[FLG_N] = n;
        f[FLG_C] = c;
        f[FLG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per cycle.
// start loads the operands; done pulses in the WIDTH-th cycle after start, with
// the final iteration folded combinationally into product so the caller can
// register it on that same edge.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] sum;

    // One shift-add step per cycle; done on the last step.
    always_comb begin
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        done     = busy_q && (cnt_q == CW'(WIDTH - 1));
        product  = sum;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    // Iteration state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with operand muxes, registered result/flags and a
// forwarding register. Define ALU_PIPE_MUL_EN to build the sequential
// multiplier for op 7; otherwise op 7 returns 0 with out_err set.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             a_sel,
    input  logic             b_sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_err
);
    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [3:0]       out_flags_q, out_flags_d;
    logic             out_err_q, out_err_d;
    logic [WIDTH-1:0] last_res_q, last_res_d;

    alu_op_e          op_e;
    logic [WIDTH-1:0] opa, opb;
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic             accept;

    assign op_e       = alu_op_e'(op);
    assign opa        = a_sel ? last_res_q : in_a;
    assign opb        = b_sel ? imm : in_b;
    assign amt        = opb[SHW-1:0];
    assign in_ready   = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign out_err    = out_err_q;

`ifdef ALU_PIPE_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (opa),
        .b       (opb),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    // Single-cycle datapath; shifts carry one extra bit so C is the last bit out.
    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_e)
            ALU_ADD: begin
                wide    = {1'b0, opa} + {1'b0, opb};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (opa[WIDTH-1] == opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
            end
            ALU_SUB: begin
                wide    = {1'b0, opa} - {1'b0, opb};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (opa[WIDTH-1] != opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
            end
            ALU_AND: alu_res = opa & opb;
            ALU_OR:  alu_res = opa | opb;
            ALU_XOR: alu_res = opa ^ opb;
            ALU_SLL: begin
                wide    = {1'b0, opa} << amt;
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            ALU_SRL: begin
                wide    = {opa, 1'b0} >> amt;
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            default: alu_res = '0;
        endcase
    end

    // Control: accept, output register load/drain, forward register update.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        out_err_d    = out_err_q;
        last_res_d   = last_res_q;
`ifdef ALU_PIPE_MUL_EN
        mul_start    = 1'b0;
`endif
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_e == ALU_MUL) begin
`ifdef ALU_PIPE_MUL_EN
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
`else
                        out_valid_d  = 1'b1;
                        out_result_d = '0;
                        out_flags_d  = pack_flags(1'b1, 1'b0, 1'b0, 1'b0);
                        out_err_d    = 1'b1;
`endif
                    end else begin
                        out_valid_d  = 1'b1;
                        out_result_d = alu_res;
                        out_flags_d  = pack_flags(alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v);
                        out_err_d    = 1'b0;
                        last_res_d   = alu_res;
                    end
                end
            end
            ST_MUL: begin
`ifdef ALU_PIPE_MUL_EN
                if (mul_done) begin
                    out_valid_d  = 1'b1;
                    out_result_d = mul_prod[WIDTH-1:0];
                    out_flags_d  = pack_flags(mul_prod[WIDTH-1:0] == '0, mul_prod[WIDTH-1],
                                              |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
                    out_err_d    = 1'b0;
                    last_res_d   = mul_prod[WIDTH-1:0];
                    state_d      = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, output and forward registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            out_err_q    <= 1'b0;
            last_res_q   <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            out_err_q    <= out_err_d;
            last_res_q   <= last_res_d;
        end
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 16-bit ALU datapath driven from `TOP`. It has the following features:
- Configurable width.
- Operand-A forwarding and operand-B immediate muxes.
- A registered result with flags.
- Valid/ready flow control on both sides.
- An optional multi-cycle shift-add multiplier.

It sits between the instruction decode stage and the register writeback stage.

## Interface
Parameters:
- `WIDTH`, 16, datapath width in bits; must be ≥4 and a power of 2.
- `SHW`, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- `clk`, input, 1, rising-edge clock.
- `rst`, input, 1, asynchronous active-low reset.
- `in_valid`, input, 1, operation presented.
- `in_ready`, output, 1, block accepts operation this cycle.
- `op`, input, 3, 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL.
- `a_sel`, input, 1, 0 selects `in_a`, 1 selects the last result (forward).
- `b_sel`, input, 1, 0 selects `in_b`, 1 selects `imm`.
- `in_a`, `in_b`, `imm`, input, WIDTH, operands.
- `out_valid`, output, 1, result register holds a valid result.
- `out_ready`, input, 1, consumer takes the result.
- `out_result`, output, WIDTH, result.
- `out_flags`, output, 4, {Z, N, C, V}.
- `out_err`, output, 1, unsupported op executed.

## Operation
- Accept on `in_valid && in_ready`; operands are captured after the mux.
- `in_ready` = (state IDLE) && (!out_valid || out_ready).
- States:
  - IDLE: single-cycle ops load the output register directly, state stays IDLE. MUL (when enabled) goes to MUL.
  - MUL: one shift-add iteration per cycle for WIDTH cycles, then loads the output register and returns to IDLE.
- Output register: loaded on completion. `out_valid` clears on `out_ready` unless a new load occurs in the same cycle (load wins, `out_valid` stays 1).
- Forward register `last_res` is updated with every completed result, independent of drain.
- Arithmetic: results are truncated to WIDTH.
- ADD: C = carry out. V = signed overflow.
- SUB: C = borrow (a<b unsigned). V = signed overflow.
- Logic ops: C = V = 0.
- SLL/SRL: shift amount = B[SHW-1:0], zero fill, C = last bit shifted out (0 if amount 0), V = 0.
- MUL: unsigned low WIDTH bits. C = 1 if any of the high WIDTH product bits is nonzero. V = 0.
- Z = (result==0); N = result[WIDTH-1] for all ops.
- `out_err` = 0 except as described under Configuration.

## Timing
- Reset values: `out_valid` 0, `out_result` 0, `out_flags` 0, `out_err` 0, `last_res` 0, state IDLE.
- `in_ready` is 1 out of reset.
- Single-cycle ops: accepted at edge N, `out_valid` = 1 after edge N. Throughput is 1/cycle with `out_ready` held at 1.
- MUL: accepted at edge N, result valid after edge N+WIDTH. `in_ready` = 0 throughout.
- Back-to-back forward: an op accepted the cycle after a producer sees the new `last_res`.
- Backpressure: `out_valid && !out_ready` holds `out_result`/`out_flags` stable and forces `in_ready` = 0.
- Reset asserted mid-MUL: the operation aborts, all state returns to reset values, and no result is produced.

## Configuration
- `ALU_PIPE_MUL_EN` defined: op 7 runs the multiplier as specified above.
- Undefined: no multiplier logic. Op 7 completes in 1 cycle with result 0, flags {Z=1, N=0, C=0, V=0}, and `out_err` = 1. Op 7 does not update `last_res`.

## Structure
- `alu_pkg` holds:
  - op enum (`ALU_ADD`..`ALU_MUL`)
  - flag bit indices (`FLG_Z`, `FLG_N`, `FLG_C`, `FLG_V`)
  - state enum (`ST_IDLE`, `ST_MUL`)
- Sub-module `alu_mul_seq` (WIDTH-parameterised shift-add multiplier):
  - start/done pulses
  - 2·WIDTH product output
  - instantiated only under `ALU_PIPE_MUL_EN`

## Test plan
- ADD, a=3, b=2, `out_ready`=1 → `out_result`=5, flags 0000, `out_valid` one cycle after accept.
- SUB, a=2, b=3 → 0xFFFF, N=1, C=1, V=0. ADD 0x7FFF+0x0001 → 0x8000, N=1, V=1, C=0.
- Forwarding: ADD 3+2, then next cycle `a_sel`=1, `b_sel`=1, imm=10, ADD → 15. SLL of 0x8001 by 1 → 0x0002, C=1.
- Backpressure: `out_ready`=0 for 3 cycles after a result → result/flags stable, `in_ready`=0. A second op is accepted in the drain cycle and its result is valid the next cycle.
- MUL with macro: 300×300 → 0x5F90, C=1, valid 16 cycles after accept. Without macro: op 7 → 0, Z=1, `out_err`=1.
- Reset pulse 8 cycles into a MUL → `out_valid`=0, `in_ready`=1, and a subsequent ADD 1+1 → 2.
